mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/rr_pick3.sv | 19 +
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] PORT_IF  = 2'd0;
  localparam logic [1:0] PORT_D   = 2'd1;
  localparam logic [1:0] PORT_DBG = 2'd2;

  localparam int unsigned MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-command signals of the arbiter, bundled with
// a requester-side (master) and arbiter-side (slave) view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic                  if_gnt, d_gnt, dbg_gnt;
  logic                  if_done, d_done, dbg_done;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  if_gnt, d_gnt, dbg_gnt, if_done, d_done, dbg_done,
    input  rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output if_gnt, d_gnt, dbg_gnt, if_done, d_done, dbg_done,
    output rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin pick: searches upward from last+1, wrapping.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = 2'd0;
    case (last)
      2'd0:    idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving three requesters serialized access to a single-port
// memory with fixed read latency; one access in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            win_q, win_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]            done_q, done_d;

  logic [2:0] req_vec;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic       issue;

  assign req_vec = {bus.dbg_req, bus.d_req, bus.if_req};

  rr_pick3 u_pick (
    .req   (req_vec),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 3'b000;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StIssue;
          win_d   = pick_idx;
          last_d  = pick_idx;
          unique case (pick_idx)
            PORT_D: begin
              we_d    = bus.d_we;
              addr_d  = bus.d_addr;
              wdata_d = bus.d_wdata;
            end
            PORT_DBG: begin
              we_d    = bus.dbg_we;
              addr_d  = bus.dbg_addr;
              wdata_d = bus.dbg_wdata;
            end
            default: begin
              // Instruction fetch is read-only.
              we_d    = 1'b0;
              addr_d  = bus.if_addr;
              wdata_d = '0;
            end
          endcase
        end
      end
      StIssue: begin
        if (MEM_LAT == 1) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = 3'(MEM_LAT - 1);
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
        done_d  = 3'b001 << win_q;
        if (!we_q) rdata_d = bus.mem_rdata;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= PORT_DBG;
      win_q   <= PORT_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign issue         = (state_q == StIssue) && !reset;
  assign bus.if_gnt    = issue && (win_q == PORT_IF);
  assign bus.d_gnt     = issue && (win_q == PORT_D);
  assign bus.dbg_gnt   = issue && (win_q == PORT_DBG);
  assign bus.if_done   = done_q[0] && !reset;
  assign bus.d_done    = done_q[1] && !reset;
  assign bus.dbg_done  = done_q[2] && !reset;
  assign bus.busy      = (state_q != StIdle) && !reset;
  assign bus.rdata     = reset ? '0 : rdata_q;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue && we_q;
  assign bus.mem_addr  = issue ? addr_q : '0;
  assign bus.mem_wdata = issue ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 3, 4), each with a memory
// responder and a transaction-level model compared every cycle, plus directed checks.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int lat_of [3] = '{1, 3, 4};

  logic [2:0] rst_s = 3'b111;
  logic [2:0] req_s   [3];
  logic [2:0] we_s    [3];
  logic [7:0] addr_s  [3][3];
  logic [7:0] wd_s    [3][3];
  logic [2:0] gnt_s   [3];
  logic [2:0] done_s  [3];
  logic       busy_s  [3];
  logic [7:0] rdata_s [3];
  logic       men_s   [3];
  logic       mwe_s   [3];
  logic [7:0] maddr_s [3];
  logic [7:0] mwd_s   [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

    mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_LAT(L)) u_dut (
      .clk   (clk),
      .reset (rst_s[g]),
      .bus   (bus)
    );

    assign bus.if_req    = req_s[g][0];
    assign bus.if_addr   = addr_s[g][0];
    assign bus.d_req     = req_s[g][1];
    assign bus.d_we      = we_s[g][1];
    assign bus.d_addr    = addr_s[g][1];
    assign bus.d_wdata   = wd_s[g][1];
    assign bus.dbg_req   = req_s[g][2];
    assign bus.dbg_we    = we_s[g][2];
    assign bus.dbg_addr  = addr_s[g][2];
    assign bus.dbg_wdata = wd_s[g][2];
    assign gnt_s[g]   = {bus.dbg_gnt, bus.d_gnt, bus.if_gnt};
    assign done_s[g]  = {bus.dbg_done, bus.d_done, bus.if_done};
    assign busy_s[g]  = bus.busy;
    assign rdata_s[g] = bus.rdata;
    assign men_s[g]   = bus.mem_en;
    assign mwe_s[g]   = bus.mem_we;
    assign maddr_s[g] = bus.mem_addr;
    assign mwd_s[g]   = bus.mem_wdata;

    // Memory: unwritten locations read as addr ^ 0x4A; data appears only in cycle mem_en+L.
    bit       wr_v [256];
    bit [7:0] wmem [256];
    int       rd_cyc = -1;
    bit [7:0] rd_dat = 8'h00;

    function automatic logic [7:0] mval(input logic [7:0] a);
      return wr_v[a] ? wmem[a] : (a ^ 8'h4A);
    endfunction

    assign bus.mem_rdata = (cyc == rd_cyc) ? rd_dat : 8'hEE;

    always @(posedge clk) begin
      if (bus.mem_en) begin
        if (bus.mem_we) begin
          wr_v[bus.mem_addr] <= 1'b1;
          wmem[bus.mem_addr] <= bus.mem_wdata;
        end else begin
          rd_cyc <= cyc + L;
          rd_dat <= mval(bus.mem_addr);
        end
      end
    end

    // Model: a transaction granted at t_iss completes at t_iss+L, done reported one cycle later.
    int       last = 2, t_iss = -10, win = 0, dn_cyc = -10, dn_port = 0;
    bit       act = 1'b0, m_we = 1'b0;
    bit [7:0] m_addr = 8'h00, m_wd = 8'h00, m_rd = 8'h00;

    always @(posedge clk) begin
      bit idle, found;
      idle  = !act;
      found = 1'b0;
      if (rst_s[g]) begin
        act    = 1'b0;
        last   = 2;
        dn_cyc = -10;
        m_rd   = 8'h00;
      end else begin
        if (act && cyc == t_iss + L) begin
          act     = 1'b0;
          dn_cyc  = cyc + 1;
          dn_port = win;
          if (!m_we) m_rd = mval(m_addr);
        end
        if (idle && req_s[g] != 3'b000) begin
          for (int k = 1; k <= 3; k++) begin
            if (!found && req_s[g][(last + k) % 3]) begin
              win   = (last + k) % 3;
              found = 1'b1;
            end
          end
          act    = 1'b1;
          t_iss  = cyc + 1;
          last   = win;
          m_we   = (win != 0) && we_s[g][win];
          m_addr = addr_s[g][win];
          m_wd   = wd_s[g][win];
        end
      end
    end

    always @(negedge clk) begin
      bit         r, iss;
      logic [2:0] eg, ed;
      if (cyc > 0) begin
        r   = rst_s[g];
        iss = !r && act && (cyc == t_iss);
        eg  = iss ? 3'(1 << win) : 3'b000;
        ed  = (!r && cyc == dn_cyc) ? 3'(1 << dn_port) : 3'b000;
        chk($sformatf("L%0d c%0d gnt", L, cyc), gnt_s[g], eg);
        chk($sformatf("L%0d c%0d done", L, cyc), done_s[g], ed);
        chk($sformatf("L%0d c%0d busy", L, cyc), busy_s[g], !r && act);
        chk($sformatf("L%0d c%0d mem_en", L, cyc), men_s[g], iss);
        chk($sformatf("L%0d c%0d rdata", L, cyc), rdata_s[g], r ? 8'h00 : m_rd);
        if (iss) begin
          chk($sformatf("L%0d c%0d mem_we", L, cyc), mwe_s[g], m_we);
          chk($sformatf("L%0d c%0d mem_addr", L, cyc), maddr_s[g], m_addr);
          if (m_we) chk($sformatf("L%0d c%0d mem_wdata", L, cyc), mwd_s[g], m_wd);
        end
        if (r) begin
          chk($sformatf("L%0d c%0d rst mem_we", L, cyc), mwe_s[g], 1'b0);
          chk($sformatf("L%0d c%0d rst mem_addr", L, cyc), maddr_s[g], 8'h00);
          chk($sformatf("L%0d c%0d rst mem_wdata", L, cyc), mwd_s[g], 8'h00);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i, output int p, output int t);
    p = -1;
    t = -1;
    for (int n = 0; n < 40 && p < 0; n++) begin
      step();
      if (gnt_s[i] != 3'b000) begin
        p = gnt_s[i][0] ? 0 : (gnt_s[i][1] ? 1 : 2);
        t = cyc;
      end
    end
    if (p < 0) chk($sformatf("gnt timeout inst %0d", i), 0, 1);
  endtask

  task automatic wait_done(input int i, output int t);
    t = -1;
    for (int n = 0; n < 40 && t < 0; n++) begin
      step();
      if (done_s[i] != 3'b000) t = cyc;
    end
    if (t < 0) chk($sformatf("done timeout inst %0d", i), 0, 1);
  endtask

  task automatic rst_pulse(input int i);
    rst_s[i] = 1'b1;
    step();
    rst_s[i] = 1'b0;
  endtask

  task automatic all_ports(input int i);
    int p, t, t_prev;
    rst_pulse(i);
    req_s[i] = 3'b111;
    t_prev   = -1;
    for (int n = 0; n < 6; n++) begin
      wait_gnt(i, p, t);
      chk($sformatf("rr L%0d order %0d", lat_of[i], n), p, n % 3);
      if (n > 0) chk($sformatf("rr L%0d spacing %0d", lat_of[i], n), t - t_prev, lat_of[i] + 2);
      t_prev = t;
    end
    req_s[i] = 3'b000;
  endtask

  initial begin
    int p, t, t0, t_dn, n_en, n_dn;
    for (int i = 0; i < 3; i++) begin
      req_s[i] = 3'b000;
      we_s[i]  = 3'b000;
      for (int k = 0; k < 3; k++) begin
        addr_s[i][k] = 8'h00;
        wd_s[i][k]   = 8'h00;
      end
    end
    repeat (3) step();
    rst_s = 3'b000;

    // MEM_LAT=1 fetch of 0x10 (memory holds 0x5A).
    req_s[0][0] = 1'b1;
    addr_s[0][0] = 8'h10;
    step();
    chk("s1 if_gnt c1", gnt_s[0], 3'b001);
    chk("s1 busy c1", busy_s[0], 1'b1);
    req_s[0][0] = 1'b0;
    step();
    chk("s1 busy c2", busy_s[0], 1'b1);
    chk("s1 no done c2", done_s[0], 3'b000);
    step();
    chk("s1 if_done c3", done_s[0], 3'b001);
    chk("s1 rdata c3", rdata_s[0], 8'h5A);
    chk("s1 idle c3", busy_s[0], 1'b0);

    all_ports(0);

    // MEM_LAT=3: load 0x30 (reads 0x7A), then store 0xC3 to 0x20.
    req_s[1][1] = 1'b1;
    addr_s[1][1] = 8'h30;
    wait_gnt(1, p, t0);
    chk("s3 load port", p, 1);
    req_s[1][1] = 1'b0;
    wait_done(1, t);
    chk("s3 load latency", t - t0, 4);
    chk("s3 load rdata", rdata_s[1], 8'h7A);
    req_s[1][1] = 1'b1;
    we_s[1][1] = 1'b1;
    addr_s[1][1] = 8'h20;
    wd_s[1][1] = 8'hC3;
    t0 = cyc;
    n_en = 0;
    t_dn = -1;
    for (int n = 0; n < 8; n++) begin
      step();
      if (gnt_s[1][1]) req_s[1][1] = 1'b0;
      if (men_s[1]) begin
        n_en++;
        chk("s3 store mem_we", mwe_s[1], 1'b1);
        chk("s3 store mem_addr", maddr_s[1], 8'h20);
        chk("s3 store mem_wdata", mwd_s[1], 8'hC3);
      end
      if (done_s[1] != 3'b000) begin
        t_dn = cyc;
        chk("s3 store done port", done_s[1], 3'b010);
      end
    end
    chk("s3 store mem_en count", n_en, 1);
    chk("s3 store done latency", t_dn - t0, 5);
    chk("s3 store rdata held", rdata_s[1], 8'h7A);
    we_s[1][1] = 1'b0;

    // MEM_LAT=3: d_req held across done, if_req raised during the second access.
    req_s[1][1] = 1'b1;
    addr_s[1][1] = 8'h44;
    wait_gnt(1, p, t);
    chk("s5 first gnt", p, 1);
    wait_gnt(1, p, t);
    chk("s5 second gnt", p, 1);
    step();
    chk("s5 busy in wait", busy_s[1], 1'b1);
    req_s[1][0] = 1'b1;
    addr_s[1][0] = 8'h50;
    wait_gnt(1, p, t);
    chk("s5 if served next", p, 0);
    req_s[1][0] = 1'b0;
    wait_gnt(1, p, t);
    chk("s5 d after if", p, 1);
    req_s[1][1] = 1'b0;

    all_ports(2);

    // MEM_LAT=4: reset during WAIT aborts; port 0 then wins over port 1.
    rst_pulse(2);
    req_s[2][0] = 1'b1;
    addr_s[2][0] = 8'h11;
    step();
    chk("s4 if_gnt", gnt_s[2], 3'b001);
    req_s[2][0] = 1'b0;
    step();
    chk("s4 busy in wait", busy_s[2], 1'b1);
    rst_s[2] = 1'b1;
    step();
    rst_s[2] = 1'b0;
    step();
    chk("s4 idle after reset", busy_s[2], 1'b0);
    n_dn = 0;
    for (int n = 0; n < 8; n++) begin
      if (done_s[2] != 3'b000) n_dn++;
      step();
    end
    chk("s4 no done after abort", n_dn, 0);
    req_s[2][0] = 1'b1;
    req_s[2][1] = 1'b1;
    addr_s[2][1] = 8'h12;
    wait_gnt(2, p, t);
    chk("s4 port 0 first", p, 0);
    req_s[2] = 3'b000;

    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
